// File: rtl/lpc_host_master.sv
// lpc_host_master: LPC host-side IO read/write cycle generator.
// Drives START/CYCTYP/ADDR/DATA/TAR on LAD, then waits for the peripheral
// SYNC handshake. A missing response turns into a timed abort.
//
// state  | meaning
// -------+--------------------------------------------------------
// IDLE   | bus parked, waiting for i_req
// START  | LFRAME# low, LAD=0000 start code
// CYCTYP | cycle type/direction nibble
// ADDR   | four address nibbles, MSB first
// H_DATA | write data, low nibble then high nibble
// H_TAR1 | host drives 1111 before releasing LAD
// H_TAR2 | LAD released, not sampled
// SYNC   | sample peripheral sync codes, bounded by SYNC_TIMEOUT
// P_DATA | capture read data, low nibble then high nibble
// P_TAR1 | peripheral turnaround, first cycle
// P_TAR2 | peripheral turnaround, second cycle
// ABORT  | LFRAME# low with LAD=1111 for four cycles
module lpc_host_master #(
  parameter int unsigned SYNC_TIMEOUT = 8
) (
  input  logic        i_LPCClk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [7:0]  o_rdata,
  output logic        o_Frame,
  output logic [3:0]  o_LAD,
  output logic        o_LAD_OE,
  input  logic [3:0]  i_LAD
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    START  = 4'd1,
    CYCTYP = 4'd2,
    ADDR   = 4'd3,
    H_DATA = 4'd4,
    H_TAR1 = 4'd5,
    H_TAR2 = 4'd6,
    SYNC   = 4'd7,
    P_DATA = 4'd8,
    P_TAR1 = 4'd9,
    P_TAR2 = 4'd10,
    ABORT  = 4'd11
  } state_t;

  // Last SYNC cycle index before the timeout forces an abort.
  localparam logic [7:0] SYNC_LAST = 8'(SYNC_TIMEOUT - 1);

  state_t      state, n_state;
  logic [1:0]  cnt, n_cnt;
  logic [7:0]  sync_cnt, n_sync;
  logic        err_q, n_err;
  logic [7:0]  rdata_sh, n_rsh;
  logic        wr_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic        n_done, n_oerr;
  logic [7:0]  n_rdata;
  logic        n_frame, n_oe;
  logic [3:0]  n_lad;

  // Next-state logic plus the output values belonging to the next state,
  // so every bus output comes straight from a flop.
  always_comb begin
    n_state = state;
    n_cnt   = cnt;
    n_sync  = sync_cnt;
    n_err   = err_q;
    n_rsh   = rdata_sh;
    n_done  = 1'b0;
    n_oerr  = 1'b0;
    n_rdata = o_rdata;

    case (state)
      IDLE: begin
        if (i_req) begin
          n_state = START;
          n_cnt   = 2'd0;
          n_err   = 1'b0;
        end
      end
      START:  n_state = CYCTYP;
      CYCTYP: begin
        n_state = ADDR;
        n_cnt   = 2'd0;
      end
      ADDR: begin
        if (cnt == 2'd3) begin
          n_state = wr_q ? H_DATA : H_TAR1;
          n_cnt   = 2'd0;
        end else begin
          n_cnt = cnt + 2'd1;
        end
      end
      H_DATA: begin
        if (cnt == 2'd1) begin
          n_state = H_TAR1;
          n_cnt   = 2'd0;
        end else begin
          n_cnt = cnt + 2'd1;
        end
      end
      H_TAR1: n_state = H_TAR2;
      H_TAR2: begin
        n_state = SYNC;
        n_sync  = 8'd0;
      end
      SYNC: begin
        case (i_LAD)
          4'b0000: begin
            n_state = wr_q ? P_TAR1 : P_DATA;
            n_cnt   = 2'd0;
          end
          4'b1010: begin
            n_err   = 1'b1;
            n_state = P_TAR1;
          end
          // Wait codes and unrecognised values both keep waiting.
          default: begin
            if (sync_cnt == SYNC_LAST) begin
              n_err   = 1'b1;
              n_state = ABORT;
              n_cnt   = 2'd0;
            end else begin
              n_sync = sync_cnt + 8'd1;
            end
          end
        endcase
      end
      P_DATA: begin
        if (cnt == 2'd0) begin
          n_rsh[3:0] = i_LAD;
          n_cnt      = 2'd1;
        end else begin
          n_rsh[7:4] = i_LAD;
          n_state    = P_TAR1;
          n_cnt      = 2'd0;
        end
      end
      P_TAR1: n_state = P_TAR2;
      P_TAR2: begin
        n_state = IDLE;
        n_done  = 1'b1;
        n_oerr  = err_q;
        if (!wr_q && !err_q) n_rdata = rdata_sh;
      end
      ABORT: begin
        if (cnt == 2'd3) begin
          n_state = IDLE;
          n_cnt   = 2'd0;
          n_done  = 1'b1;
          n_oerr  = err_q;
        end else begin
          n_cnt = cnt + 2'd1;
        end
      end
      default: n_state = IDLE;
    endcase

    n_frame = 1'b1;
    n_oe    = 1'b0;
    n_lad   = 4'hF;
    case (n_state)
      START: begin
        n_frame = 1'b0;
        n_oe    = 1'b1;
        n_lad   = 4'b0000;
      end
      CYCTYP: begin
        n_oe  = 1'b1;
        n_lad = wr_q ? 4'b0010 : 4'b0000;
      end
      ADDR: begin
        n_oe = 1'b1;
        case (n_cnt)
          2'd0:    n_lad = addr_q[15:12];
          2'd1:    n_lad = addr_q[11:8];
          2'd2:    n_lad = addr_q[7:4];
          default: n_lad = addr_q[3:0];
        endcase
      end
      H_DATA: begin
        n_oe  = 1'b1;
        n_lad = (n_cnt == 2'd0) ? wdata_q[3:0] : wdata_q[7:4];
      end
      H_TAR1: n_oe = 1'b1;
      ABORT: begin
        n_frame = 1'b0;
        n_oe    = 1'b1;
      end
      default: ;
    endcase
  end

  // State, counters, request latches and registered outputs.
  always_ff @(posedge i_LPCClk) begin
    if (i_rst) begin
      state    <= IDLE;
      cnt      <= 2'd0;
      sync_cnt <= 8'd0;
      err_q    <= 1'b0;
      rdata_sh <= 8'h00;
      wr_q     <= 1'b0;
      addr_q   <= 16'h0000;
      wdata_q  <= 8'h00;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_err    <= 1'b0;
      o_rdata  <= 8'h00;
      o_Frame  <= 1'b1;
      o_LAD    <= 4'hF;
      o_LAD_OE <= 1'b0;
    end else begin
      state    <= n_state;
      cnt      <= n_cnt;
      sync_cnt <= n_sync;
      err_q    <= n_err;
      rdata_sh <= n_rsh;
      if (state == IDLE && i_req) begin
        wr_q    <= i_wr;
        addr_q  <= i_addr;
        wdata_q <= i_wdata;
      end
      o_busy   <= (n_state != IDLE);
      o_done   <= n_done;
      o_err    <= n_oerr;
      o_rdata  <= n_rdata;
      o_Frame  <= n_frame;
      o_LAD    <= n_lad;
      o_LAD_OE <= n_oe;
    end
  end

endmodule

// File: tb/tb_lpc_host_master.sv
// tb_lpc_host_master: randomized LPC transactions checked cycle by cycle
// against an expected bus waveform built from the protocol rules.
module tb_lpc_host_master;

  localparam int TMO = 8;

  logic        i_LPCClk;
  logic        i_rst;
  logic        i_req;
  logic        i_wr;
  logic [15:0] i_addr;
  logic [7:0]  i_wdata;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic [7:0]  o_rdata;
  logic        o_Frame;
  logic [3:0]  o_LAD;
  logic        o_LAD_OE;
  logic [3:0]  i_LAD;

  lpc_host_master #(.SYNC_TIMEOUT(TMO)) dut (
    .i_LPCClk (i_LPCClk),
    .i_rst    (i_rst),
    .i_req    (i_req),
    .i_wr     (i_wr),
    .i_addr   (i_addr),
    .i_wdata  (i_wdata),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_err    (o_err),
    .o_rdata  (o_rdata),
    .o_Frame  (o_Frame),
    .o_LAD    (o_LAD),
    .o_LAD_OE (o_LAD_OE),
    .i_LAD    (i_LAD)
  );

  initial i_LPCClk = 1'b0;
  always #5 i_LPCClk = ~i_LPCClk;

  typedef struct packed {
    logic       frame;
    logic       oe;
    logic [3:0] lad;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] rdata;
    logic [3:0] drv;
  } cyc_t;

  int         checks = 0;
  int         failures = 0;
  cyc_t       exp_q[$];
  logic [3:0] script_q[$];
  logic [3:0] obs_lad[$];
  int         obs_busy;
  cyc_t       cur;
  bit         cur_v = 0;
  logic [7:0] m_rdata;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic void push(input logic frame, input logic oe, input logic [3:0] lad,
                               input logic busy, input logic done, input logic err,
                               input logic [3:0] drv);
    cyc_t c;
    c.frame = frame; c.oe = oe; c.lad = lad; c.busy = busy;
    c.done = done; c.err = err; c.rdata = m_rdata; c.drv = drv;
    exp_q.push_back(c);
  endfunction

  // Expected waveform of one transaction, starting with the request cycle.
  function automatic void build(input logic wr, input logic [15:0] addr,
                                input logic [7:0] wdata,
                                input logic [3:0] dlo, input logic [3:0] dhi);
    int outcome; // 0 ready, 1 error, 2 timeout
    logic [3:0] code;
    exp_q.delete();
    push(1, 0, 4'hF, 0, 0, 0, 4'hF);
    push(0, 1, 4'h0, 1, 0, 0, 4'hF);
    push(1, 1, wr ? 4'h2 : 4'h0, 1, 0, 0, 4'hF);
    for (int i = 0; i < 4; i++) push(1, 1, 4'((addr >> (12 - 4*i)) & 16'hF), 1, 0, 0, 4'hF);
    if (wr) begin
      push(1, 1, wdata[3:0], 1, 0, 0, 4'hF);
      push(1, 1, wdata[7:4], 1, 0, 0, 4'hF);
    end
    push(1, 1, 4'hF, 1, 0, 0, 4'hF);
    push(1, 0, 4'hF, 1, 0, 0, 4'h0);  // a ready code here must be ignored
    outcome = 2;
    for (int n = 0; n < TMO; n++) begin
      code = (n < script_q.size()) ? script_q[n] : 4'hF;
      push(1, 0, 4'hF, 1, 0, 0, code);
      if (code == 4'h0) begin outcome = 0; break; end
      if (code == 4'hA) begin outcome = 1; break; end
    end
    if (outcome == 0 && !wr) begin
      push(1, 0, 4'hF, 1, 0, 0, dlo);
      push(1, 0, 4'hF, 1, 0, 0, dhi);
    end
    if (outcome != 2) begin
      push(1, 0, 4'hF, 1, 0, 0, 4'hF);
      push(1, 0, 4'hF, 1, 0, 0, 4'hF);
    end else begin
      for (int i = 0; i < 4; i++) push(0, 1, 4'hF, 1, 0, 0, 4'hF);
    end
    if (!wr && outcome == 0) m_rdata = {dhi, dlo};
    push(1, 0, 4'hF, 0, 1, (outcome != 0), 4'hF);
    push(1, 0, 4'hF, 0, 0, 0, 4'hF);
  endfunction

  // Single compare process: DUT outputs against the current expected cycle.
  always @(negedge i_LPCClk) begin
    if (cur_v) begin
      chk("frame", {7'b0, o_Frame}, {7'b0, cur.frame});
      chk("lad_oe", {7'b0, o_LAD_OE}, {7'b0, cur.oe});
      if (cur.oe) chk("lad", {4'b0, o_LAD}, {4'b0, cur.lad});
      chk("busy", {7'b0, o_busy}, {7'b0, cur.busy});
      chk("done", {7'b0, o_done}, {7'b0, cur.done});
      if (cur.done) chk("err", {7'b0, o_err}, {7'b0, cur.err});
      chk("rdata", o_rdata, cur.rdata);
      if (o_LAD_OE) obs_lad.push_back(o_LAD);
      if (o_busy) obs_busy++;
    end
  end

  // Caller is positioned 1 time unit after a rising edge in an idle cycle.
  task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [7:0] wdata,
                         input logic [3:0] dlo, input logic [3:0] dhi);
    build(wr, addr, wdata, dlo, dhi);
    obs_lad.delete();
    obs_busy = 0;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k > 0) begin @(posedge i_LPCClk); #1; end
      cur   = exp_q[k];
      cur_v = 1;
      i_LAD = cur.drv;
      if (k == 0) begin
        i_req = 1; i_wr = wr; i_addr = addr; i_wdata = wdata;
      end else if (cur.busy) begin
        i_req = 1'($urandom); i_wr = 1'($urandom);
        i_addr = 16'($urandom); i_wdata = 8'($urandom);
      end else begin
        i_req = 0;
      end
    end
    @(posedge i_LPCClk); #1;
    cur_v = 0;
    i_req = 0;
    i_LAD = 4'hF;
  endtask

  logic [3:0] lad035 [9];
  logic [3:0] waits [8];

  initial begin
    lad035 = '{4'h0, 4'h2, 4'h0, 4'h8, 4'h8, 4'h0, 4'h5, 4'hA, 4'hF};
    waits  = '{4'h5, 4'h6, 4'hF, 4'h1, 4'h3, 4'h7, 4'h9, 4'hC};
    i_rst = 1; i_req = 0; i_wr = 0; i_addr = 0; i_wdata = 0; i_LAD = 4'hF;
    m_rdata = 8'h00;
    repeat (3) @(posedge i_LPCClk);
    #1;
    chk("rst_frame", {7'b0, o_Frame}, 8'h01);
    chk("rst_oe", {7'b0, o_LAD_OE}, 8'h00);
    chk("rst_lad", {4'b0, o_LAD}, 8'h0F);
    chk("rst_busy", {7'b0, o_busy}, 8'h00);
    chk("rst_done", {7'b0, o_done}, 8'h00);
    chk("rst_err", {7'b0, o_err}, 8'h00);
    chk("rst_rdata", o_rdata, 8'h00);
    i_rst = 0;

    // Write 0x0880 <- 0xA5, one wait then ready.
    script_q = '{4'h6, 4'h0};
    run_txn(1, 16'h0880, 8'hA5, 4'h0, 4'h0);
    chk("w_lad_count", 8'(obs_lad.size()), 8'd9);
    for (int i = 0; i < 9; i++)
      if (i < obs_lad.size()) chk("w_lad_seq", {4'b0, obs_lad[i]}, {4'b0, lad035[i]});

    // Read 0x0881, immediate ready, data C then 3.
    script_q = '{4'h0};
    run_txn(0, 16'h0881, 8'h00, 4'hC, 4'h3);
    chk("r_rdata", o_rdata, 8'h3C);
    chk("r_cycles", 8'(obs_busy), 8'd13);

    // Read with no response: timeout then abort.
    script_q.delete();
    run_txn(0, 16'h1234, 8'h00, 4'h1, 4'h2);
    chk("to_cycles", 8'(obs_busy), 8'd20);
    chk("to_rdata_held", o_rdata, 8'h3C);

    // Write answered with the error code.
    script_q = '{4'hA};
    run_txn(1, 16'h00F0, 8'h5A, 4'h0, 4'h0);
    chk("werr_cycles", 8'(obs_busy), 8'd13);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      int nwait;
      nwait = $urandom_range(0, 9);
      script_q.delete();
      for (int i = 0; i < nwait; i++) script_q.push_back(waits[$urandom_range(0, 7)]);
      if (nwait < TMO) script_q.push_back(($urandom % 2) ? 4'h0 : 4'hA);
      run_txn(1'($urandom), 16'($urandom), 8'($urandom), 4'($urandom), 4'($urandom));
    end

    // Reset during ADDR abandons the transaction without a done pulse.
    i_req = 1; i_wr = 1; i_addr = 16'h1234; i_wdata = 8'h77;
    @(posedge i_LPCClk); #1;
    i_req = 0;
    @(posedge i_LPCClk); #1;
    @(posedge i_LPCClk); #1;
    chk("addr_busy", {7'b0, o_busy}, 8'h01);
    chk("addr_nib", {4'b0, o_LAD}, 8'h01);
    i_rst = 1;
    @(posedge i_LPCClk); #1;
    i_rst = 0;
    m_rdata = 8'h00;
    chk("mid_rst_frame", {7'b0, o_Frame}, 8'h01);
    chk("mid_rst_oe", {7'b0, o_LAD_OE}, 8'h00);
    chk("mid_rst_busy", {7'b0, o_busy}, 8'h00);
    chk("mid_rst_done", {7'b0, o_done}, 8'h00);
    chk("mid_rst_rdata", o_rdata, 8'h00);

    // Request in the first cycle after reset deasserts.
    script_q = '{4'h5, 4'h0};
    run_txn(0, 16'hBEEF, 8'h00, 4'h9, 4'h6);
    chk("post_rst_rdata", o_rdata, 8'h69);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lpc_host_master.md
LPC_HOST_MASTER -- requirements
Module: lpc_host_master

Interface
REQ-001 SHALL have parameter SYNC_TIMEOUT, default 8, giving the maximum SYNC cycles spent waiting for a ready or error code before abort (legal range 2..255).
REQ-002 SHALL have port i_LPCClk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port i_req, input, 1 bit: command request, sampled only in IDLE.
REQ-005 SHALL have port i_wr, input, 1 bit: 1 selects IO write, 0 selects IO read.
REQ-006 SHALL have port i_addr, input, 16 bits: IO address.
REQ-007 SHALL have port i_wdata, input, 8 bits: write data.
REQ-008 SHALL have port o_busy, output, 1 bit: a transaction is in progress.
REQ-009 SHALL have port o_done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port o_err, output, 1 bit: error qualifier, valid when o_done=1.
REQ-011 SHALL have port o_rdata, output, 8 bits: read data.
REQ-012 SHALL have port o_Frame, output, 1 bit: LFRAME#, active low.
REQ-013 SHALL have ports o_LAD (output, 4 bits), o_LAD_OE (output, 1 bit) and i_LAD (input, 4 bits): the LAD bus drive value, drive enable and sampled value.

Function
REQ-014 SHALL use states IDLE, START, CYCTYP, ADDR, H_DATA, H_TAR1, H_TAR2, SYNC, P_DATA, P_TAR1, P_TAR2, ABORT.
REQ-015 IDLE SHALL drive o_Frame=1 and o_LAD_OE=0; when i_req=1 it SHALL latch i_wr, i_addr and i_wdata, and go to START on the next cycle.
REQ-016 i_req SHALL be ignored in every state except IDLE; o_busy SHALL be 1 in every state except IDLE.
REQ-017 START SHALL last 1 cycle with o_Frame=0, o_LAD_OE=1, o_LAD=4'b0000.
REQ-018 CYCTYP SHALL last 1 cycle with o_Frame=1, o_LAD_OE=1, and o_LAD=4'b0010 for write or 4'b0000 for read.
REQ-019 ADDR SHALL last 4 cycles driving latched addr[15:12], [11:8], [7:4], [3:0] in that order, using a 2-bit counter.
REQ-020 After ADDR, a write SHALL go to H_DATA and a read SHALL go to H_TAR1.
REQ-021 H_DATA SHALL last 2 cycles driving wdata[3:0] then wdata[7:4].
REQ-022 H_TAR1 SHALL last 1 cycle with o_LAD_OE=1 and o_LAD=4'hF.
REQ-023 H_TAR2 SHALL last 1 cycle with o_LAD_OE=0; i_LAD SHALL NOT be sampled in H_TAR2.
REQ-024 SYNC SHALL keep o_LAD_OE=0, sample i_LAD every cycle, and decode it as follows:
- 4'b0000: ready; a read goes to P_DATA, a write goes to P_TAR1.
- 4'b0101 or 4'b0110: wait; stay in SYNC.
- 4'b1010: error; set the error flag and go to P_TAR1.
- any other value, including 4'hF: treat as no response; stay in SYNC.
REQ-025 The SYNC cycle counter SHALL be 8 bits and clear on SYNC entry; if SYNC_TIMEOUT cycles elapse without ready or error, the block SHALL set the error flag and go to ABORT.
REQ-026 P_DATA SHALL last 2 cycles, capturing i_LAD into rdata[3:0] then rdata[7:4]; o_LAD_OE=0.
REQ-027 P_TAR1 and P_TAR2 SHALL last 1 cycle each with o_LAD_OE=0, then return to IDLE.
REQ-028 ABORT SHALL last 4 cycles with o_Frame=0, o_LAD_OE=1, o_LAD=4'hF, then drive o_Frame=1 and return to IDLE.
REQ-029 o_done SHALL pulse for exactly 1 cycle, registered, on the first IDLE cycle after P_TAR2 or ABORT; o_err SHALL be 1 in that cycle if the error flag is set, and 0 otherwise.
REQ-030 o_rdata SHALL update only on a successful read completion (o_done=1, o_err=0) and hold its value otherwise.
REQ-031 A write with a 0-cycle wait (first SYNC sample 0000) SHALL take 13 cycles from START through P_TAR2; a read with a 0-cycle wait SHALL also take 13 cycles.
REQ-032 Any undefined state encoding SHALL return to IDLE on the next cycle with o_LAD_OE=0.

Reset
REQ-033 When i_rst=1 at a clock edge, regardless of state, the block SHALL enter IDLE with o_Frame=1, o_LAD_OE=0, o_LAD=4'hF, o_busy=0, o_done=0, o_err=0, o_rdata=8'h00, and all counters and latches cleared.
REQ-034 A reset in the middle of a transaction SHALL abandon the transaction with no o_done pulse; a request presented in the cycle after reset deasserts SHALL be accepted.

Verification
REQ-035 Write 0x0880, data 0xA5; slave SYNC returns 0110 then 0000 -> LAD sequence 0,2,0,8,8,0,5,A,F, then released; o_done=1, o_err=0.
REQ-036 Read 0x0881; slave SYNC returns 0000, then data nibbles C,3 -> o_rdata=0x3C, o_err=0, total 13 cycles from START.
REQ-037 Read with no slave response (i_LAD=F) and SYNC_TIMEOUT=8 -> 8 SYNC cycles, 4 ABORT cycles with Frame=0 and LAD=F, then o_done=1, o_err=1, and o_rdata unchanged.
REQ-038 Write; slave SYNC returns 1010 -> P_TAR1, P_TAR2, then o_done=1, o_err=1.
REQ-039 Pulse i_req while busy -> ignored; reset asserted in ADDR -> the next cycle is IDLE with Frame=1, OE=0, and no o_done.
